// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB pipeline register with load align and writeback select (optional WB_RETIRE_CNT_EN retire counter)
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_stall,
    input  logic              in_flush,
    input  logic              in_regwrite,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [1:0]        in_wb_sel,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_signed,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_write_en,
    output logic [REG_AW-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              wb_valid,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]       retire_count,
`endif
    output logic              wb_misalign
);

    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_dest;
    logic [1:0]        wb_sel;
    logic [1:0]        wb_ld_size;
    logic              wb_ld_signed;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_pc;

    logic [1:0]        off;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] load_data;
    logic              is_load;

    // WB register: reset clears everything, flush only kills the slot, stall freezes
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_dest      <= '0;
            wb_sel       <= 2'b00;
            wb_ld_size   <= 2'b00;
            wb_ld_signed <= 1'b0;
            wb_alu       <= '0;
            wb_pc        <= '0;
        end else if (in_flush) begin
            wb_valid     <= 1'b0;
        end else if (!in_stall) begin
            wb_valid     <= in_valid;
            wb_regwrite  <= in_regwrite;
            wb_dest      <= in_dest;
            wb_sel       <= in_wb_sel;
            wb_ld_size   <= in_ld_size;
            wb_ld_signed <= in_ld_signed;
            wb_alu       <= in_alu_result;
            wb_pc        <= in_pc;
        end
    end

    // Big-endian lane extraction and extension of the loaded word
    always_comb begin
        off       = wb_alu[1:0];
        byte_lane = 8'h00;
        case (off)
            2'd0:    byte_lane = mem_rdata[31:24];
            2'd1:    byte_lane = mem_rdata[23:16];
            2'd2:    byte_lane = mem_rdata[15:8];
            default: byte_lane = mem_rdata[7:0];
        endcase
        half_lane = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (wb_ld_size)
            2'b00:   load_data = {{(DATA_W-8){wb_ld_signed & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{(DATA_W-16){wb_ld_signed & half_lane[15]}}, half_lane};
            default: load_data = mem_rdata;
        endcase
    end

    // Writeback select, misalign detection and register-file write port
    always_comb begin
        is_load     = (wb_sel == 2'b01);
        wb_misalign = wb_valid & is_load &
                      (((wb_ld_size == 2'b01) & off[0]) | (wb_ld_size[1] & (off != 2'b00)));
        case (wb_sel)
            2'b01:   reg_write_data = load_data;
            2'b10:   reg_write_data = wb_pc + DATA_W'(8);
            default: reg_write_data = wb_alu;
        endcase
        reg_write_dest = wb_dest;
        reg_write_en   = wb_valid & wb_regwrite & (wb_dest != '0) & !wb_misalign;
    end

`ifdef WB_RETIRE_CNT_EN
    // Count instructions leaving WB; flush does not clear the running total
    always_ff @(posedge clk) begin
        if (reset)
            retire_count <= 32'd0;
        else if (wb_valid & !in_stall & !wb_misalign)
            retire_count <= retire_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - scoreboard testbench for mem_wb_writeback
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_stall, in_flush, in_regwrite, in_ld_signed;
    logic [4:0]  in_dest;
    logic [1:0]  in_wb_sel, in_ld_size;
    logic [31:0] in_alu_result, in_pc, mem_rdata;
    logic        reg_write_en, wb_valid, wb_misalign;
    logic [4:0]  reg_write_dest;
    logic [31:0] reg_write_data;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    typedef struct {
        string       name;
        logic        valid;
        logic        we;
        logic        mis;
        logic        chk_data;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_writeback dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_stall(in_stall),
        .in_flush(in_flush), .in_regwrite(in_regwrite), .in_dest(in_dest),
        .in_wb_sel(in_wb_sel), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
        .in_alu_result(in_alu_result), .in_pc(in_pc), .mem_rdata(mem_rdata),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .wb_valid(wb_valid),
`ifdef WB_RETIRE_CNT_EN
        .retire_count(retire_count),
`endif
        .wb_misalign(wb_misalign)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: one expected entry per WB cycle, compared away from the capture edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".valid"}, 32'(wb_valid), 32'(e.valid));
            check({e.name, ".we"}, 32'(reg_write_en), 32'(e.we));
            check({e.name, ".misalign"}, 32'(wb_misalign), 32'(e.mis));
            if (e.chk_data) begin
                check({e.name, ".dest"}, 32'(reg_write_dest), 32'(e.dest));
                check({e.name, ".data"}, reg_write_data, e.data);
            end
        end
    end

    // Drive one MEM-stage slot, let it be captured, present rdata for the WB cycle, queue expectation
    task automatic step(input logic rst, input logic v, input logic stl, input logic fl,
                        input logic rw, input logic [4:0] d, input logic [1:0] sel,
                        input logic [1:0] sz, input logic sgn, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] rd, input exp_t e);
        reset = rst; in_valid = v; in_stall = stl; in_flush = fl; in_regwrite = rw;
        in_dest = d; in_wb_sel = sel; in_ld_size = sz; in_ld_signed = sgn;
        in_alu_result = alu; in_pc = pc;
        @(posedge clk);
        #1;
        mem_rdata = rd;
        exp_q.push_back(e);
    endtask

    function automatic exp_t mk(input string nm, input logic v, input logic we, input logic mis,
                                input logic cd, input logic [4:0] d, input logic [31:0] dat);
        exp_t e;
        e.name = nm; e.valid = v; e.we = we; e.mis = mis; e.chk_data = cd; e.dest = d; e.data = dat;
        return e;
    endfunction

    initial begin
        int waits;
        reset = 1'b1; in_valid = 1'b0; in_stall = 1'b0; in_flush = 1'b0; in_regwrite = 1'b0;
        in_dest = 5'd0; in_wb_sel = 2'b00; in_ld_size = 2'b00; in_ld_signed = 1'b0;
        in_alu_result = 32'd0; in_pc = 32'd0; mem_rdata = 32'd0;
        @(posedge clk);
        #1;

        step(1, 0, 0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0,
             mk("reset", 0, 0, 0, 1, 5'd0, 32'h0));
        step(0, 1, 0, 0, 1, 5'd5, 2'b00, 2'b00, 0, 32'h1234, 32'h0, 32'h0,
             mk("alu", 1, 1, 0, 1, 5'd5, 32'h1234));
        step(0, 1, 0, 0, 1, 5'd0, 2'b00, 2'b00, 0, 32'hFFFFFFFF, 32'h0, 32'h0,
             mk("r0_guard", 1, 0, 0, 1, 5'd0, 32'hFFFFFFFF));
        step(0, 1, 0, 0, 1, 5'd8, 2'b01, 2'b00, 1, 32'h1001, 32'h0, 32'h00FF8000,
             mk("lb_off1", 1, 1, 0, 1, 5'd8, 32'hFFFFFFFF));
        step(0, 1, 0, 0, 1, 5'd8, 2'b01, 2'b00, 0, 32'h1001, 32'h0, 32'h00FF8000,
             mk("lbu_off1", 1, 1, 0, 1, 5'd8, 32'h000000FF));
        step(0, 1, 0, 0, 1, 5'd9, 2'b01, 2'b00, 1, 32'h1002, 32'h0, 32'h00FF8000,
             mk("lb_off2", 1, 1, 0, 1, 5'd9, 32'hFFFFFF80));
        step(0, 1, 0, 0, 1, 5'd9, 2'b01, 2'b00, 1, 32'h1000, 32'h0, 32'h7F123456,
             mk("lb_off0", 1, 1, 0, 1, 5'd9, 32'h0000007F));
        step(0, 1, 0, 0, 1, 5'd10, 2'b01, 2'b10, 0, 32'h1002, 32'h0, 32'h00FF8000,
             mk("lw_misalign", 1, 0, 1, 0, 5'd10, 32'h0));
        step(0, 1, 0, 0, 1, 5'd10, 2'b01, 2'b01, 0, 32'h1002, 32'h0, 32'h00FF8000,
             mk("lhu_off2", 1, 1, 0, 1, 5'd10, 32'h00008000));
        step(0, 1, 0, 0, 1, 5'd11, 2'b01, 2'b01, 1, 32'h1000, 32'h0, 32'hFF7F0001,
             mk("lh_off0", 1, 1, 0, 1, 5'd11, 32'hFFFFFF7F));
        step(0, 1, 0, 0, 1, 5'd11, 2'b01, 2'b01, 1, 32'h1001, 32'h0, 32'h00FF8000,
             mk("lh_misalign", 1, 0, 1, 0, 5'd11, 32'h0));
        step(0, 1, 0, 0, 1, 5'd12, 2'b01, 2'b10, 0, 32'h1004, 32'h0, 32'hDEADBEEF,
             mk("lw_ok", 1, 1, 0, 1, 5'd12, 32'hDEADBEEF));
        step(0, 1, 0, 0, 1, 5'd31, 2'b10, 2'b00, 0, 32'h0, 32'h00400010, 32'h0,
             mk("jal", 1, 1, 0, 1, 5'd31, 32'h00400018));
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 0, 1, 5'd3, 2'b00, 2'b00, 0, 32'h9, 32'h0, 32'h55555555,
                 mk($sformatf("stall%0d", i), 1, 1, 0, 1, 5'd31, 32'h00400018));
        step(0, 1, 0, 0, 1, 5'd2, 2'b10, 2'b00, 0, 32'h0, 32'hFFFFFFFC, 32'h0,
             mk("link_wrap", 1, 1, 0, 1, 5'd2, 32'h00000004));
        step(0, 1, 1, 1, 1, 5'd6, 2'b00, 2'b00, 0, 32'h77, 32'h0, 32'h0,
             mk("flush_stall", 0, 0, 0, 1, 5'd2, 32'h00000004));
        step(0, 1, 0, 0, 1, 5'd7, 2'b00, 2'b00, 0, 32'hA5A5, 32'h0, 32'h0,
             mk("alu2", 1, 1, 0, 1, 5'd7, 32'hA5A5));
        step(1, 1, 0, 0, 1, 5'd7, 2'b00, 2'b00, 0, 32'hA5A5, 32'h0, 32'h0,
             mk("reset_mid", 0, 0, 0, 1, 5'd0, 32'h0));
        step(0, 0, 0, 0, 1, 5'd9, 2'b00, 2'b00, 0, 32'h55, 32'h0, 32'h0,
             mk("bubble", 0, 0, 0, 1, 5'd9, 32'h55));

`ifdef WB_RETIRE_CNT_EN
        check("cnt_after_reset", retire_count, 32'd0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 0, 1, 5'(i + 1), 2'b00, 2'b00, 0, 32'(i + 100), 32'h0, 32'h0,
                 mk($sformatf("cnt_alu%0d", i), 1, 1, 0, 1, 5'(i + 1), 32'(i + 100)));
        step(0, 0, 0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0,
             mk("cnt_idle", 0, 0, 0, 1, 5'd0, 32'h0));
        check("cnt_four", retire_count, 32'd4);
        step(1, 0, 0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0,
             mk("cnt_reset", 0, 0, 0, 1, 5'd0, 32'h0));
        check("cnt_cleared", retire_count, 32'd0);
`endif

        waits = 0;
        while (exp_q.size() > 0 && waits < 50) begin
            @(posedge clk);
            waits++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
